// File: rtl/clock_key_conditioner.sv
// Two-key conditioner: sync, debounce and optional auto-repeat for the clock.
// Ports: CLOCK_50, RST (async high), MIN_RAW/HR_RAW (raw, active-low) in;
//   MIN_KEY/HR_KEY (one-cycle active-low strobes), held[1:0] (hr, min) out.
// Build option: define KEY_AUTOREPEAT_EN for held-key auto-repeat strobes.
module clock_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       MIN_RAW,
  input  logic       HR_RAW,
  output logic       MIN_KEY,
  output logic       HR_KEY,
  output logic [1:0] held
);

  localparam int CW = 32;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL
  } state_t;

  logic [1:0] raw;
  logic [1:0] kv;
  logic [1:0] hv;

  assign raw     = {HR_RAW, MIN_RAW};
  assign MIN_KEY = kv[0];
  assign HR_KEY  = kv[1];
  assign held    = hv;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          s1, s2, sync;
    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt, cinc;
    logic          strb, fire;
    logic          rd_due, rr_due;
    logic          hold_o, key_o;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
      end else begin
        s1 <= raw[c];
        s2 <= s1;
      end
    end

    assign sync = s2;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
        state <= IDLE;
        cnt   <= '0;
        strb  <= 1'b0;
      end else begin
        state <= nstate;
        cnt   <= ncnt;
        strb  <= fire;
      end
    end

    // Saturating increment; the strobe guard keeps strobes apart
    // even for degenerate one-cycle delay/rate settings.
    assign cinc   = (cnt == CMAX) ? cnt : cnt + ONE;
    assign rd_due = (cnt >= RD_LAST) && !strb;
    assign rr_due = (cnt >= RR_LAST) && !strb;

    // Debounce states test the incremented count so that the
    // first low sample (seen in IDLE) counts as stable cycle one.
    always_comb begin
      nstate = state;
      ncnt   = cnt;
      fire   = 1'b0;
      unique case (state)
        IDLE: begin
          if (!sync) begin
            nstate = DEB_PRESS;
            ncnt   = '0;
          end
        end
        DEB_PRESS: begin
          if (sync) begin
            nstate = IDLE;
            ncnt   = '0;
          end else if (cinc >= DB_LAST) begin
            nstate = HELD;
            ncnt   = '0;
            fire   = 1'b1;
          end else begin
            ncnt = cinc;
          end
        end
        HELD: begin
          if (sync) begin
            nstate = DEB_REL;
            ncnt   = '0;
          end else if (AR_EN && rd_due) begin
            nstate = REPEAT;
            ncnt   = '0;
            fire   = 1'b1;
          end else begin
            ncnt = cinc;
          end
        end
        REPEAT: begin
          if (sync) begin
            nstate = DEB_REL;
            ncnt   = '0;
          end else if (rr_due) begin
            ncnt = '0;
            fire = 1'b1;
          end else begin
            ncnt = cinc;
          end
        end
        DEB_REL: begin
          if (!sync) begin
            nstate = HELD;
            ncnt   = '0;
          end else if (cinc >= DB_LAST) begin
            nstate = IDLE;
            ncnt   = '0;
          end else begin
            ncnt = cinc;
          end
        end
        default: begin
          nstate = IDLE;
          ncnt   = '0;
        end
      endcase
    end

    always_comb begin
      hold_o = (state == HELD) || (state == REPEAT) ||
               (state == DEB_REL);
      key_o  = ~strb;
    end

    assign hv[c] = hold_o;
    assign kv[c] = key_o;
  end

endmodule

// File: tb/tb_clock_key_conditioner.sv
// Randomized and directed bench for clock_key_conditioner.
// Checks every cycle against a run-length model of the key rules.
module tb_clock_key_conditioner;

  localparam int D  = 4;
  localparam int R  = 20;
  localparam int RR = 8;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       RST;
  logic       MIN_RAW;
  logic       HR_RAW;
  logic       MIN_KEY;
  logic       HR_KEY;
  logic [1:0] held;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;

  bit m_p1[2], m_p2[2], m_held[2], m_strb[2];
  int m_low[2], m_high[2], m_t[2];

  clock_key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(R),
    .REPEAT_RATE(RR)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST(RST),
    .MIN_RAW(MIN_RAW),
    .HR_RAW(HR_RAW),
    .MIN_KEY(MIN_KEY),
    .HR_KEY(HR_KEY),
    .held(held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_p1[c] = 1; m_p2[c] = 1;
      m_held[c] = 0; m_strb[c] = 0;
      m_low[c] = 0; m_high[c] = 0; m_t[c] = 0;
    end
  endfunction

  // Key is accepted after D consecutive low synchronized samples,
  // released after D consecutive high ones; repeats follow held time.
  function automatic void model_edge(int c, bit raw);
    bit s;
    s = m_p2[c];
    m_p2[c] = m_p1[c];
    m_p1[c] = raw;
    m_strb[c] = 0;
    if (!m_held[c]) begin
      if (!s) begin
        m_low[c]++;
        if (m_low[c] == D) begin
          m_held[c] = 1; m_t[c] = 0;
          m_high[c] = 0; m_strb[c] = 1;
        end
      end else begin
        m_low[c] = 0;
      end
    end else if (s) begin
      m_high[c]++;
      if (m_high[c] == D) begin
        m_held[c] = 0; m_low[c] = 0;
      end
    end else if (m_high[c] > 0) begin
      m_high[c] = 0; m_t[c] = 0;
    end else begin
      m_t[c]++;
      if (AR && m_t[c] >= R && (m_t[c] - R) % RR == 0)
        m_strb[c] = 1;
    end
  endfunction

  function automatic logic [3:0] model_out();
    return {~m_strb[0], ~m_strb[1], m_held[1], m_held[0]};
  endfunction

  task automatic tick(input logic mr, input logic hr);
    MIN_RAW = mr;
    HR_RAW  = hr;
    @(posedge CLOCK_50);
    if (RST) model_reset();
    else begin
      model_edge(0, mr);
      model_edge(1, hr);
    end
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    RST = 1; MIN_RAW = 1; HR_RAW = 1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    model_reset();
    RST = 0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    RST = 1; MIN_RAW = 0; HR_RAW = 0;
    #1;
    got = {MIN_KEY, HR_KEY, held};
    total++;
    if (got !== 4'b1100)
      $display("FAIL reset_async got %b want 1100", got);
    else passed++;
    repeat (3) @(posedge CLOCK_50);
    #1;
    got = {MIN_KEY, HR_KEY, held};
    total++;
    if (got !== 4'b1100)
      $display("FAIL reset_held got %b want 1100", got);
    else passed++;
  endtask

  task automatic test_clean_press();
    logic [3:0] got;
    int first, n;
    do_reset();
    first = -1; n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 1);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL clean e%0d got %b want %b",
                 edge_n, got, model_out());
      else passed++;
      if (MIN_KEY === 1'b0) begin
        n++;
        if (first < 0) first = edge_n;
      end
      if (edge_n == 6) begin
        total++;
        if (held[0] !== 1'b1)
          $display("FAIL clean_held e6 got %b want 1", held[0]);
        else passed++;
      end
    end
    total++;
    if (first != 6)
      $display("FAIL clean_edge got %0d want 6", first);
    else passed++;
    total++;
    if (n != 1)
      $display("FAIL clean_count got %0d want 1", n);
    else passed++;
  endtask

  task automatic test_bounce();
    logic [3:0] got;
    logic r;
    int first, n;
    do_reset();
    first = -1; n = 0;
    for (int i = 0; i < 16; i++) begin
      r = (i == 3);
      tick(r, 1);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL bounce e%0d got %b want %b",
                 edge_n, got, model_out());
      else passed++;
      if (MIN_KEY === 1'b0) begin
        n++;
        if (first < 0) first = edge_n;
      end
    end
    total++;
    if (first != 10 || n != 1)
      $display("FAIL bounce_strobe got e%0d x%0d want e10 x1",
               first, n);
    else passed++;
  endtask

  task automatic test_autorepeat();
    logic [3:0] got;
    int q[$];
    int e[$];
    do_reset();
    e.push_back(6);
    if (AR) begin
      e.push_back(26); e.push_back(34); e.push_back(42);
      e.push_back(50); e.push_back(58);
    end
    for (int i = 0; i < 70; i++) begin
      tick(1, i >= 60);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL repeat e%0d got %b want %b",
                 edge_n, got, model_out());
      else passed++;
      if (HR_KEY === 1'b0) q.push_back(edge_n);
    end
    total++;
    if (q.size() != e.size())
      $display("FAIL repeat_count got %0d want %0d",
               q.size(), e.size());
    else passed++;
    for (int i = 0; i < e.size() && i < q.size(); i++) begin
      total++;
      if (q[i] != e[i])
        $display("FAIL repeat_edge%0d got %0d want %0d",
                 i, q[i], e[i]);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL simul e%0d got %b want %b",
                 edge_n, got, model_out());
      else passed++;
      if (edge_n == 6) begin
        total++;
        if (got !== 4'b0011)
          $display("FAIL simul_e6 got %b want 0011", got);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    int first, n;
    do_reset();
    tick(0, 1);
    tick(0, 1);
    RST = 1;
    #1;
    got = {MIN_KEY, HR_KEY, held};
    total++;
    if (got !== 4'b1100)
      $display("FAIL rstmid_async got %b want 1100", got);
    else passed++;
    tick(0, 1);
    got = {MIN_KEY, HR_KEY, held};
    total++;
    if (got !== 4'b1100)
      $display("FAIL rstmid_edge got %b want 1100", got);
    else passed++;
    RST = 0;
    edge_n = 0;
    first = -1; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL rstmid e%0d got %b want %b",
                 edge_n, got, model_out());
      else passed++;
      if (MIN_KEY === 1'b0) begin
        n++;
        if (first < 0) first = edge_n;
      end
    end
    total++;
    if (first != 6 || n != 1)
      $display("FAIL rstmid_strobe got e%0d x%0d want e6 x1",
               first, n);
    else passed++;
  endtask

  task automatic test_release();
    logic [3:0] got;
    logic r;
    int n;
    do_reset();
    n = 0;
    // press, short release, re-press, real release
    for (int i = 0; i < 34; i++) begin
      r = (i >= 10 && i < 12) || (i >= 22 && i < 26);
      tick(r, 1);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL release e%0d got %b want %b",
                 edge_n, got, model_out());
      else passed++;
      if (MIN_KEY === 1'b0) n++;
      if (edge_n > 6 && edge_n <= 27) begin
        total++;
        if (held[0] !== 1'b1)
          $display("FAIL release_held e%0d got %b want 1",
                   edge_n, held[0]);
        else passed++;
      end
      if (edge_n == 28) begin
        total++;
        if (held[0] !== 1'b0)
          $display("FAIL release_drop got %b want 0", held[0]);
        else passed++;
      end
    end
    total++;
    if (n != 2)
      $display("FAIL release_count got %0d want 2", n);
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0] got;
    bit lv[2];
    logic r0, r1;
    do_reset();
    lv[0] = 1; lv[1] = 1;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 29) == 0) lv[c] = ~lv[c];
      r0 = lv[0] ^ ($urandom_range(0, 11) == 0);
      r1 = lv[1] ^ ($urandom_range(0, 11) == 0);
      RST = (i == 400);
      tick(r0, r1);
      got = {MIN_KEY, HR_KEY, held};
      total++;
      if (got !== model_out())
        $display("FAIL random i%0d got %b want %b",
                 i, got, model_out());
      else passed++;
    end
    RST = 0;
  endtask

  initial begin
    RST = 1; MIN_RAW = 1; HR_RAW = 1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_simultaneous();
    test_reset_mid();
    test_release();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_key_conditioner.md
CLOCK_KEY_CONDITIONER -- requirements
Module: clock_key_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a press or release (20 ms at 50 MHz).
REQ-003 Parameter REPEAT_DELAY, default 25000000: held cycles after the first pulse before auto-repeat starts (500 ms).
REQ-004 Parameter REPEAT_RATE, default 10000000: cycles between auto-repeat pulses (200 ms).
REQ-005 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 MIN_RAW  input  1  raw minute pushbutton, active-low, asynchronous, bouncing.
REQ-008 HR_RAW  input  1  raw hour pushbutton, active-low, asynchronous, bouncing.
REQ-009 MIN_KEY  output  1  active-low one-cycle increment strobe to the datapath minute input.
REQ-010 HR_KEY  output  1  active-low one-cycle increment strobe to the datapath hour input.
REQ-011 held  output  2  bit0 = minute key debounced-held, bit1 = hour key debounced-held.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer; logic uses only the synchronized value (sync).
REQ-013 Minute and hour channels SHALL be identical, independent instances of one per-channel FSM with a private counter at least 25 bits wide.
REQ-014 FSM states SHALL be IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL.
REQ-015 IDLE: sync=0 -> DEB_PRESS, counter cleared; otherwise stay.
REQ-016 DEB_PRESS: counter increments while sync=0; sync=1 -> IDLE with no strobe; counter reaching DEBOUNCE_CYCLES-1 with sync=0 -> HELD, counter cleared, strobe asserted for exactly that next cycle.
REQ-017 Strobe latency SHALL be DEBOUNCE_CYCLES+2 rising edges from the first edge sampling raw=0, for a bounce-free press.
REQ-018 HELD: sync=1 -> DEB_REL; counter reaching REPEAT_DELAY-1 -> REPEAT with one strobe (when auto-repeat is compiled in).
REQ-019 REPEAT: one strobe every REPEAT_RATE cycles while sync=0; sync=1 -> DEB_REL.
REQ-020 DEB_REL: sync=1 for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any sync=0 -> HELD, counter cleared, no strobe.
REQ-021 held bit SHALL be 1 in HELD, REPEAT and DEB_REL, else 0.
REQ-022 Strobes SHALL always be exactly one cycle low and never back-to-back on one channel.
REQ-023 Simultaneous presses: both channels SHALL operate independently; both strobes may be low in the same cycle.
REQ-024 Counters SHALL saturate, never wrap, in any state.

Reset
REQ-025 RST high SHALL immediately force both FSMs to IDLE, counters and synchronizers to 0/idle, MIN_KEY=1, HR_KEY=1, held=2'b00.
REQ-026 Synchronizer flops SHALL reset to 1 (released key).
REQ-027 Reset asserted mid-press SHALL abort the press with no strobe; after release of RST a still-held key SHALL be re-debounced from DEB_PRESS.

Configuration
REQ-028 Macro KEY_AUTOREPEAT_EN defined: HELD->REPEAT and REPEAT strobes SHALL be enabled as in REQ-018/019.
REQ-029 KEY_AUTOREPEAT_EN undefined: HELD SHALL never exit to REPEAT, REPEAT SHALL be unreachable, exactly one strobe per debounced press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-030 Clean press: MIN_RAW low held -> MIN_KEY low exactly one cycle at edge 6, held[0]=1 from the same cycle, HR_KEY stays 1.
REQ-031 Bounce: MIN_RAW low 3 cycles, high 1, low steady -> no strobe during the glitch; single strobe 6 edges after the final falling edge.
REQ-032 Auto-repeat (macro defined): hold HR_RAW 60 cycles -> HR_KEY strobes at edges 6, 26, 34, 42, 50, 58; none with macro undefined except edge 6.
REQ-033 Simultaneous: both raw keys low in the same cycle -> MIN_KEY and HR_KEY low in the same cycle, held=2'b11.
REQ-034 Reset mid-operation: RST pulse at edge 3 of a press -> no strobe; outputs 1/1/00 during RST; strobe 6 edges after RST falls with key still held.
REQ-035 Release debounce: release for 2 cycles then re-press -> no new strobe, held stays 1; release for 4 cycles -> held returns 0.
